// File: rtl/neuron_mac_unit.sv
// Single-neuron MAC datapath in signed Q32.32: streams N_INPUTS (x, w) beats,
// accumulates bias + sum(x*w) with saturation, applies the selected activation
// and hands the result to the next layer over a valid/ready output.
module neuron_mac_unit #(
  parameter int N_INPUTS = 4,
  parameter int CNT_W    = $clog2(N_INPUTS + 1)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [63:0] bias,
  input  logic [1:0]  act_sel,
  output logic        busy,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [63:0] in_x,
  input  logic [63:0] in_w,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_y,
  output logic [63:0] out_sum,
  output logic        sat_flag
);

  localparam logic signed [63:0]  ONE   = 64'sh0000_0001_0000_0000;
  localparam logic signed [63:0]  NEG1  = -64'sh0000_0001_0000_0000;
  localparam logic signed [63:0]  HALF  = 64'sh0000_0000_8000_0000;
  localparam logic signed [63:0]  MAXV  = 64'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [63:0]  MINV  = 64'sh8000_0000_0000_0000;
  localparam logic [CNT_W-1:0]    LAST  = CNT_W'(N_INPUTS - 1);

  typedef enum logic [1:0] {IDLE = 2'd0, ACCUM = 2'd1, ACT = 2'd2, DONE = 2'd3} state_t;

  state_t             state;
  logic signed [63:0] acc;
  logic [1:0]         act_q;
  logic [CNT_W-1:0]   count;

  logic signed [127:0] x_ext;
  logic signed [127:0] w_ext;
  logic signed [127:0] prod_full;
  logic signed [63:0]  prod;
  logic signed [64:0]  sum65;

  // Clamp a 65-bit sum back into the signed 64-bit range.
  function automatic logic signed [63:0] sat64(input logic signed [64:0] s);
    if (s[64] != s[63]) return s[64] ? MINV : MAXV;
    return s[63:0];
  endfunction

  // True when the 65-bit sum does not fit in 64 bits.
  function automatic logic sat_hit(input logic signed [64:0] s);
    return s[64] != s[63];
  endfunction

  // Activation functions on the final accumulator value.
  function automatic logic signed [63:0] activate(input logic signed [63:0] a,
                                                  input logic [1:0] sel);
    logic signed [63:0] sig;
    sig = (a >>> 2) + HALF;
    case (sel)
      2'd0:    return (a >= 64'sd0) ? ONE : 64'sd0;
      2'd1:    return (sig < 64'sd0) ? 64'sd0 : ((sig > ONE) ? ONE : sig);
      2'd2:    return (a < NEG1) ? NEG1 : ((a > ONE) ? ONE : a);
      default: return a[63] ? 64'sd0 : a;
    endcase
  endfunction

  // Full-precision product realigned to Q32.32 (wraps), and widened accumulate.
  always_comb begin
    x_ext     = {{64{in_x[63]}}, in_x};
    w_ext     = {{64{in_w[63]}}, in_w};
    prod_full = x_ext * w_ext;
    prod      = 64'(prod_full >>> 32);
    sum65     = {acc[63], acc} + {prod[63], prod};
  end

  // Status outputs decode straight from the state register.
  assign busy      = (state != IDLE);
  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);

  // Operation sequencer and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      act_q    <= '0;
      count    <= '0;
      out_y    <= '0;
      out_sum  <= '0;
      sat_flag <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            acc      <= bias;
            act_q    <= act_sel;
            count    <= '0;
            sat_flag <= 1'b0;
            state    <= ACCUM;
          end
        end
        ACCUM: begin
          if (in_valid) begin
            acc   <= sat64(sum65);
            count <= count + 1'b1;
            if (sat_hit(sum65)) sat_flag <= 1'b1;
            if (count == LAST) state <= ACT;
          end
        end
        ACT: begin
          out_sum <= acc;
          out_y   <= activate(acc, act_q);
          state   <= DONE;
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_neuron_mac_unit.sv
// Directed bench for neuron_mac_unit with a behavioural Q32.32 reference model.
module tb_neuron_mac_unit;

  localparam int N = 4;
  localparam logic signed [63:0]  ONE    = 64'sh0000_0001_0000_0000;
  localparam logic signed [127:0] MAX128 = 128'sh7FFF_FFFF_FFFF_FFFF;
  localparam logic signed [127:0] MIN128 = -(128'sh8000_0000_0000_0000);

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [63:0] bias;
  logic [1:0]  act_sel;
  logic        busy;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_x;
  logic [63:0] in_w;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_y;
  logic [63:0] out_sum;
  logic        sat_flag;

  int n_checks = 0;
  int n_fail   = 0;

  logic [63:0] vx [N];
  logic [63:0] vw [N];
  logic [63:0] exp_y;
  logic [63:0] exp_sum;
  logic        exp_sat;

  neuron_mac_unit #(.N_INPUTS(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias), .act_sel(act_sel),
    .busy(busy), .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x),
    .in_w(in_w), .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y),
    .out_sum(out_sum), .sat_flag(sat_flag)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, expv);
    end
  endtask

  // Reference: exact arithmetic on wide integers, clamped to the 64-bit range after every beat.
  function automatic void model(input logic [63:0] b, input logic [1:0] a,
                                output logic [63:0] s, output logic [63:0] y,
                                output logic sat);
    logic signed [127:0] accw, xs, ws, p;
    logic signed [63:0]  v, t;
    accw = {{64{b[63]}}, b};
    sat  = 1'b0;
    for (int i = 0; i < N; i++) begin
      xs = {{64{vx[i][63]}}, vx[i]};
      ws = {{64{vw[i][63]}}, vw[i]};
      p  = (xs * ws) >>> 32;
      p  = {{64{p[63]}}, p[63:0]};
      accw = accw + p;
      if (accw > MAX128) begin accw = MAX128; sat = 1'b1; end
      else if (accw < MIN128) begin accw = MIN128; sat = 1'b1; end
    end
    s = accw[63:0];
    v = accw[63:0];
    case (a)
      2'd0: y = (v >= 64'sd0) ? ONE : 64'sd0;
      2'd1: begin
        t = (v >>> 2) + 64'sh8000_0000;
        y = (t < 64'sd0) ? 64'sd0 : ((t > ONE) ? ONE : t);
      end
      2'd2: y = (v < -ONE) ? -ONE : ((v > ONE) ? ONE : v);
      default: y = (v < 64'sd0) ? 64'sd0 : v;
    endcase
  endfunction

  // Whenever a result is presented it must match the model.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && out_valid === 1'b1) begin
      check("cmp_y", out_y, exp_y);
      check("cmp_sum", out_sum, exp_sum);
      check("cmp_sat", 64'(sat_flag), 64'(exp_sat));
    end
  end

  task automatic set_vec(input logic [63:0] x, input logic [63:0] w);
    for (int i = 0; i < N; i++) begin vx[i] = x; vw[i] = w; end
  endtask

  task automatic do_op(input logic [63:0] b, input logic [1:0] a, input bit gaps,
                       input int hold, input bit pulse_start);
    int k;
    model(b, a, exp_sum, exp_y, exp_sat);
    k = 0;
    while (busy !== 1'b0 && k < 20) begin @(posedge clk); #1; k++; end
    check("idle_before_start", 64'(busy), 64'd0);
    start = 1'b1; bias = b; act_sel = a;
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_accum", 64'(busy), 64'd1);
    check("sat_cleared", 64'(sat_flag), 64'd0);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        int g;
        g = $urandom_range(0, 3);
        repeat (g) begin @(posedge clk); #1; end
      end
      in_valid = 1'b1; in_x = vx[i]; in_w = vw[i];
      check("in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
    check("lat_act_valid", 64'(out_valid), 64'd0);
    check("lat_act_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    check("lat_done_valid", 64'(out_valid), 64'd1);
    for (int h = 0; h < hold; h++) begin
      if (pulse_start) start = 1'b1;
      @(posedge clk); #1;
      check("hold_valid", 64'(out_valid), 64'd1);
      check("hold_busy", 64'(busy), 64'd1);
    end
    start = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("valid_dropped", 64'(out_valid), 64'd0);
    check("busy_idle", 64'(busy), 64'd0);
    check("keep_y", out_y, exp_y);
    check("keep_sum", out_sum, exp_sum);
  endtask

  initial begin
    #300000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; bias = '0; act_sel = '0;
    in_valid = 1'b0; in_x = '0; in_w = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_out_y", out_y, 64'd0);
    check("rst_out_sum", out_sum, 64'd0);
    check("rst_sat", 64'(sat_flag), 64'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ReLU of 4 x (1.0 * 0.5) = 2.0
    set_vec(64'h0000_0001_0000_0000, 64'h0000_0000_8000_0000);
    do_op(64'd0, 2'd3, 1'b0, 0, 1'b0);
    check("relu_y", out_y, 64'h0000_0002_0000_0000);
    check("relu_sum", out_sum, 64'h0000_0002_0000_0000);
    check("relu_sat", 64'(sat_flag), 64'd0);

    // Same with random in_valid gaps
    do_op(64'd0, 2'd3, 1'b1, 0, 1'b0);
    check("gap_y", out_y, 64'h0000_0002_0000_0000);

    // Hard sigmoid on bias-only sums
    set_vec(64'd0, 64'h0000_0001_0000_0000);
    do_op(64'd0, 2'd1, 1'b0, 0, 1'b0);
    check("sig_0", out_y, 64'h0000_0000_8000_0000);
    do_op(64'hFFFF_FFFF_0000_0000, 2'd1, 1'b0, 0, 1'b0);
    check("sig_m1", out_y, 64'h0000_0000_4000_0000);
    do_op(64'h0000_0004_0000_0000, 2'd1, 1'b0, 0, 1'b0);
    check("sig_4", out_y, 64'h0000_0001_0000_0000);
    do_op(64'hFFFF_FFFD_0000_0000, 2'd1, 1'b0, 0, 1'b0);
    check("sig_m3", out_y, 64'd0);

    // Sigmoid of -1.0 built from negative products: 4 x (-1.0 * 0.25)
    set_vec(64'hFFFF_FFFF_0000_0000, 64'h0000_0000_4000_0000);
    do_op(64'd0, 2'd1, 1'b0, 0, 1'b0);
    check("sig_prod_sum", out_sum, 64'hFFFF_FFFF_0000_0000);
    check("sig_prod_y", out_y, 64'h0000_0000_4000_0000);

    // Tanh of -2.5, with output held off 5 cycles and start pulsed in DONE
    set_vec(64'd0, 64'h0000_0001_0000_0000);
    do_op(64'hFFFF_FFFD_8000_0000, 2'd2, 1'b0, 5, 1'b1);
    check("tanh_sum", out_sum, 64'hFFFF_FFFD_8000_0000);
    check("tanh_y", out_y, 64'hFFFF_FFFF_0000_0000);
    check("no_queued_start", 64'(busy), 64'd0);
    do_op(64'hFFFF_FFFD_8000_0000, 2'd0, 1'b0, 0, 1'b0);
    check("step_neg", out_y, 64'd0);

    // Positive saturation
    set_vec(64'h4000_0000_0000_0000, 64'h0000_0001_0000_0000);
    do_op(64'd0, 2'd0, 1'b0, 0, 1'b0);
    check("sat_sum", out_sum, 64'h7FFF_FFFF_FFFF_FFFF);
    check("sat_flag", 64'(sat_flag), 64'd1);
    check("sat_step", out_y, 64'h0000_0001_0000_0000);

    // Next operation clears the sticky flag
    set_vec(64'h0000_0001_0000_0000, 64'h0000_0000_8000_0000);
    do_op(64'd0, 2'd3, 1'b0, 0, 1'b0);
    check("sat_cleared_after", 64'(sat_flag), 64'd0);

    // Mixed vector with wrapping product and negative saturation, model only
    vx[0] = 64'h7FFF_FFFF_0000_0000; vw[0] = 64'h7FFF_FFFF_0000_0000;
    vx[1] = 64'hC000_0000_0000_0000; vw[1] = 64'h0000_0002_0000_0000;
    vx[2] = 64'h8000_0000_0000_0000; vw[2] = 64'h0000_0001_0000_0000;
    vx[3] = 64'h0000_0003_4000_0000; vw[3] = 64'hFFFF_FFFE_C000_0000;
    do_op(64'h0000_0000_1234_5678, 2'd2, 1'b1, 2, 1'b0);

    // Reset in the middle of an operation
    set_vec(64'h4000_0000_0000_0000, 64'h0000_0001_0000_0000);
    start = 1'b1; bias = 64'h0000_0005_0000_0000; act_sel = 2'd3;
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1; in_x = vx[i]; in_w = vw[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_in_ready", 64'(in_ready), 64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_out_y", out_y, 64'd0);
    check("abort_out_sum", out_sum, 64'd0);
    check("abort_sat", 64'(sat_flag), 64'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    set_vec(64'h0000_0001_0000_0000, 64'h0000_0000_8000_0000);
    do_op(64'd0, 2'd3, 1'b0, 0, 1'b0);
    check("fresh_y", out_y, 64'h0000_0002_0000_0000);
    check("fresh_sum", out_sum, 64'h0000_0002_0000_0000);
    check("fresh_sat", 64'(sat_flag), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
